sdram_dev_model: RTL and testbench
==================================

Name: sdram_dev_model

Overview:
Cycle-level responder for the SDRAM device pins: the device end of the controller's pin interface, consuming cke/cs/ras/cas/we/dqm/addr/ba/write_data/wr_en and producing read_data.
- Decodes JEDEC commands, tracks per-bank open rows and the mode register, and serves bursts from an internal 16-bit backing store.
- Flags protocol violations.
- Used as the device in controller benches and as an FPGA loopback target.

Parameters:
- ADDR_WIDTH, 24, flat word address width (matches the controller).
- COL_WIDTH, 9, column address bits.
- ROW_WIDTH, ADDR_WIDTH-COL_WIDTH-3, row address bits.
- STORE_AW, 12, backing-store index width: 2^STORE_AW 16-bit words; the {ba,row,col} index is truncated to its low STORE_AW bits (aliasing is allowed).

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cke  in  1  clock enable; when low, the command is ignored.
- cs  in  1  chip select; low = selected (JEDEC levels on cs/ras/cas/we).
- ras  in  1  row strobe, low asserted.
- cas  in  1  column strobe, low asserted.
- we  in  1  write enable, low asserted.
- dqm  in  2  byte masks: [0] = low byte, [1] = high byte; high = masked.
- addr  in  ROW_WIDTH  row/column/mode address; addr[10] = all-banks flag on PRECHARGE.
- ba  in  2  bank address.
- write_data  in  16  write data.
- wr_en  in  1  controller driving DQ; write data is sampled only when high.
- read_data  out  16  read data; 0 when not valid.
- rd_valid  out  1  read_data carries a burst word this cycle.
- err  out  1  sticky; set on any violation, cleared only by rst.
- err_code  out  4  code of the first violation; held until rst.

Behaviour:
- Command decode when cke=1 and cs=0, as {ras,cas,we}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE
  - 001 AUTO_REFRESH
  - 000 LOAD_MODE
  - 110 BURST_TERM
- cs=1 or cke=0 is treated as NOP.
- Reset values:
  - read_data=0, rd_valid=0, err=0, err_code=0.
  - All banks idle; mode_loaded=0.
  - Mode is CL=3, BL=1.
  - Burst engine idle; read pipe flushed.
  - Backing store is not cleared.
- LOAD_MODE:
  - BL = addr[2:0]: 0/1/2/3 → 1/2/4/8.
  - CL = addr[6:4]: only 2 and 3 are legal; anything else sets err code 1 and keeps the old CL.
  - Sets mode_loaded. LOAD_MODE with any bank open sets err code 2 but is still applied.
- ACTIVE: opens bank ba with row=addr. ACTIVE on an already open bank sets err code 3 and replaces the row.
- PRECHARGE:
  - Closes bank ba, or all banks if addr[10]=1.
  - Precharging an idle bank is legal.
  - If it closes the bank of an active burst, the burst stops issuing further columns.
- AUTO_REFRESH: with any bank open, sets err code 4. No data effect.
- READ/WRITE to an idle bank sets err code 5 and is ignored.
- READ/WRITE before mode_loaded sets err code 6 but executes with the current mode.
- Column index: column = addr[COL_WIDTH-1:0]. Burst word k uses column with its low log2(BL) bits replaced by (start+k) mod BL: sequential order, wrapping within the BL-aligned block.
- READ issued at cycle T:
  - Burst engine issues word k at T+k, k=0..BL-1.
  - Each issued word enters a CL-deep pipe and appears on read_data with rd_valid=1 at T+k+CL.
  - Read mask: dqm sampled at the issue cycle, i.e. 2 cycles ahead of the data for CL=2, of each word zeroes the masked byte of that word.
- WRITE issued at cycle T:
  - Word k is written at T+k from write_data, only if wr_en=1. A masked byte keeps its stored value.
  - wr_en=0 during a write burst sets err code 7 and skips that word.
- Interruptions:
  - A new READ/WRITE during a burst terminates the old burst immediately; the new one starts at its issue cycle.
  - BURST_TERM stops the burst after the current cycle.
  - Words already in the read pipe always drain.
- Read/write collision: a WRITE issued while read words are still draining sets err code 8 (bus contention). The write proceeds and the drain continues.
- Reset mid-burst: rst flushes the burst and pipe; outputs go to reset values the next cycle.
- Error priority: when several violations occur in one cycle, the lowest code is captured.

Decomposition:
- Package sdram_pkg:
  - sdram_cmd_e enum (the 8 commands).
  - Pure function decode_cmd(cs,ras,cas,we).
  - Mode-field localparams: BL_LSB=0, CL_LSB=4, AP_BIT=10.
  - err_code localparams ERR_CL .. ERR_CONTEND (1..8).
- Sub-module sdram_rd_pipe: variable-latency (2 or 3) shift pipe carrying {valid, data, mask}, with a synchronous flush on rst.

Test Plan:
- LOAD_MODE addr=0x020 (CL=2,BL=1); ACTIVE ba=1 row=0x0A5; WRITE col=0x010 data=0xBEEF; READ col=0x010 at T → read_data=0xBEEF, rd_valid=1 only at T+2; err=0.
- LOAD_MODE addr=0x033 (CL=3,BL=8); write 8 words 0x1000..0x1007 at col 0; READ col=5 at T → T+3..T+10 output 0x1005,0x1006,0x1007,0x1000..0x1004.
- BL=4 write col 0 with dqm=2'b01 on word 1 over prior 0xAAAA → word1 reads 0xXXAA with the high byte new and the low byte 0xAA retained; other words full.
- BL=8 CL=2 READ at T, BURST_TERM at T+2 → exactly 3 rd_valid words (T+2..T+4), then rd_valid=0.
- READ to an idle bank → err=1, err_code=5, rd_valid stays 0; then ACTIVE twice on bank 0 → err_code stays 5 (first violation held).
- rst asserted at T+1 of a CL=3 BL=4 read → rd_valid=0 from T+2 onward; after reset, READ before LOAD_MODE → err_code=6, data at CL=3.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared command encoding, mode-register field positions and violation codes
// for the SDRAM device model.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } sdram_cmd_e;

  localparam int BL_LSB = 0;
  localparam int CL_LSB = 4;
  localparam int AP_BIT = 10;

  localparam logic [3:0] ERR_CL        = 4'd1;
  localparam logic [3:0] ERR_MODE_OPEN = 4'd2;
  localparam logic [3:0] ERR_ACT_OPEN  = 4'd3;
  localparam logic [3:0] ERR_REFRESH   = 4'd4;
  localparam logic [3:0] ERR_IDLE      = 4'd5;
  localparam logic [3:0] ERR_NO_MODE   = 4'd6;
  localparam logic [3:0] ERR_WR_GAP    = 4'd7;
  localparam logic [3:0] ERR_CONTEND   = 4'd8;

  function automatic sdram_cmd_e decode_cmd(input logic cs, input logic ras,
                                            input logic cas, input logic we);
    if (cs) return CMD_NOP;
    return sdram_cmd_e'({ras, cas, we});
  endfunction

  // Index of the last word in a burst of 2^bl_code words (also the wrap mask).
  function automatic logic [2:0] bl_last(input logic [1:0] bl_code);
    return 3'((4'd1 << bl_code) - 4'd1);
  endfunction

  // Low column bits of burst word k: sequential order, wrapping inside the BL block.
  function automatic logic [2:0] burst_low(input logic [2:0] start, input logic [1:0] bl_code,
                                           input logic [2:0] k);
    logic [2:0] m;
    m = bl_last(bl_code);
    return (start & ~m) | ((start + k) & m);
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency pipe for read words: stage 1 takes its data from the registered
// backing-store read, the output tap is stage 2 (CL=2) or stage 3 (CL=3).
module sdram_rd_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cl,
  input  logic        in_valid,
  input  logic [1:0]  in_mask,
  input  logic [15:0] mem_q,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        busy
);

  logic [2:0]  v_q, v_d;
  logic [1:0]  m_q [3];
  logic [1:0]  m_d [3];
  logic [15:0] d_q [1:2];
  logic [15:0] d_d [1:2];
  logic [15:0] raw;
  logic [1:0]  msk;

  always_comb begin
    v_d    = {v_q[1:0], in_valid};
    m_d[0] = in_mask;
    m_d[1] = m_q[0];
    m_d[2] = m_q[1];
    d_d[1] = mem_q;
    d_d[2] = d_q[1];
  end

  always_comb begin
    out_valid = (cl == 2'd2) ? v_q[1] : v_q[2];
    raw       = (cl == 2'd2) ? d_q[1] : d_q[2];
    msk       = (cl == 2'd2) ? m_q[1] : m_q[2];
    out_data  = out_valid ? (raw & {{8{~msk[1]}}, {8{~msk[0]}}}) : 16'h0000;
    // Stage 3 only holds a live word when it is the output tap.
    busy      = v_q[0] | v_q[1] | ((cl == 2'd3) & v_q[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
    m_q <= m_d;
    d_q <= d_d;
  end

endmodule

// File: rtl/sdram_dev_model.sv
// Device-side SDRAM responder: decodes pin commands, tracks banks and mode,
// runs read/write bursts against a byte-lane backing store and flags violations.
module sdram_dev_model
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int COL_WIDTH  = 9,
  parameter int ROW_WIDTH  = ADDR_WIDTH - COL_WIDTH - 3,
  parameter int STORE_AW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 we,
  input  logic [1:0]           dqm,
  input  logic [ROW_WIDTH-1:0] addr,
  input  logic [1:0]           ba,
  input  logic [15:0]          write_data,
  input  logic                 wr_en,
  output logic [15:0]          read_data,
  output logic                 rd_valid,
  output logic                 err,
  output logic [3:0]           err_code
);

  sdram_cmd_e cmd;
  logic [3:0]           bank_open_q, bank_open_d;
  logic [ROW_WIDTH-1:0] bank_row_q [4];
  logic [ROW_WIDTH-1:0] bank_row_d [4];
  logic [1:0]           cl_q, cl_d, bl_q, bl_d;
  logic                 mode_loaded_q, mode_loaded_d;
  logic                 bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
  logic [1:0]           bst_bank_q, bst_bank_d, bst_bl_q, bst_bl_d;
  logic [ROW_WIDTH-1:0] bst_row_q, bst_row_d;
  logic [COL_WIDTH-1:0] bst_col_q, bst_col_d;
  logic [2:0]           bst_k_q, bst_k_d;
  logic                 err_q, err_d;
  logic [3:0]           err_code_q, err_code_d;

  logic                 iss, iss_wr;
  logic [1:0]           iss_bank;
  logic [ROW_WIDTH-1:0] iss_row;
  logic [COL_WIDTH-1:0] iss_col;
  logic [STORE_AW-1:0]  iss_idx;
  logic [1:0]           lane_we;
  logic [8:1]           viol;
  logic [3:0]           first_code;
  logic                 pipe_busy;
  logic [15:0]          mem_rd;

  always_comb begin
    cmd           = cke ? decode_cmd(cs, ras, cas, we) : CMD_NOP;
    bank_open_d   = bank_open_q;
    bank_row_d    = bank_row_q;
    cl_d          = cl_q;
    bl_d          = bl_q;
    mode_loaded_d = mode_loaded_q;
    bst_act_d     = bst_act_q;
    bst_wr_d      = bst_wr_q;
    bst_bank_d    = bst_bank_q;
    bst_bl_d      = bst_bl_q;
    bst_row_d     = bst_row_q;
    bst_col_d     = bst_col_q;
    bst_k_d       = bst_k_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    viol          = '0;
    iss           = 1'b0;
    iss_wr        = 1'b0;
    iss_bank      = bst_bank_q;
    iss_row       = bst_row_q;
    iss_col       = {bst_col_q[COL_WIDTH-1:3], burst_low(bst_col_q[2:0], bst_bl_q, bst_k_q)};

    case (cmd)
      CMD_LOAD_MODE: begin
        viol[ERR_MODE_OPEN] = |bank_open_q;
        if (addr[CL_LSB +: 3] == 3'd2 || addr[CL_LSB +: 3] == 3'd3) cl_d = addr[CL_LSB +: 2];
        else viol[ERR_CL] = 1'b1;
        bl_d          = addr[BL_LSB +: 2];
        mode_loaded_d = 1'b1;
      end
      CMD_ACTIVE: begin
        viol[ERR_ACT_OPEN] = bank_open_q[ba];
        bank_open_d[ba]    = 1'b1;
        bank_row_d[ba]     = addr;
      end
      CMD_PRECHARGE: begin
        if (addr[AP_BIT]) bank_open_d = '0;
        else              bank_open_d[ba] = 1'b0;
      end
      CMD_REFRESH: viol[ERR_REFRESH] = |bank_open_q;
      CMD_READ, CMD_WRITE: begin
        viol[ERR_IDLE]    = ~bank_open_q[ba];
        viol[ERR_NO_MODE] = ~mode_loaded_q;
        viol[ERR_CONTEND] = (cmd == CMD_WRITE) && bank_open_q[ba] && pipe_busy;
      end
      default: ;
    endcase

    // A legal READ/WRITE preempts any running burst and issues its word 0 now.
    if ((cmd == CMD_READ || cmd == CMD_WRITE) && bank_open_q[ba]) begin
      iss        = 1'b1;
      iss_wr     = (cmd == CMD_WRITE);
      iss_bank   = ba;
      iss_row    = bank_row_q[ba];
      iss_col    = addr[COL_WIDTH-1:0];
      bst_act_d  = (bl_q != 2'd0);
      bst_wr_d   = (cmd == CMD_WRITE);
      bst_bank_d = ba;
      bst_row_d  = bank_row_q[ba];
      bst_col_d  = addr[COL_WIDTH-1:0];
      bst_bl_d   = bl_q;
      bst_k_d    = 3'd1;
    end else if (bst_act_q) begin
      iss     = 1'b1;
      iss_wr  = bst_wr_q;
      bst_k_d = bst_k_q + 3'd1;
      if (bst_k_q == bl_last(bst_bl_q) || cmd == CMD_BURST_TERM || !bank_open_d[bst_bank_q])
        bst_act_d = 1'b0;
    end

    if (iss && iss_wr && !wr_en) viol[ERR_WR_GAP] = 1'b1;
    lane_we = (iss && iss_wr && wr_en) ? ~dqm : 2'b00;
    iss_idx = STORE_AW'({iss_bank, iss_row, iss_col});

    first_code = 4'd0;
    for (int i = 8; i >= 1; i--) if (viol[i]) first_code = 4'(i);
    if (!err_q && first_code != 4'd0) begin
      err_d      = 1'b1;
      err_code_d = first_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_q   <= '0;
      cl_q          <= 2'd3;
      bl_q          <= 2'd0;
      mode_loaded_q <= 1'b0;
      bst_act_q     <= 1'b0;
      bst_wr_q      <= 1'b0;
      bst_bank_q    <= '0;
      bst_bl_q      <= '0;
      bst_row_q     <= '0;
      bst_col_q     <= '0;
      bst_k_q       <= '0;
      err_q         <= 1'b0;
      err_code_q    <= 4'd0;
    end else begin
      bank_open_q   <= bank_open_d;
      bank_row_q    <= bank_row_d;
      cl_q          <= cl_d;
      bl_q          <= bl_d;
      mode_loaded_q <= mode_loaded_d;
      bst_act_q     <= bst_act_d;
      bst_wr_q      <= bst_wr_d;
      bst_bank_q    <= bst_bank_d;
      bst_bl_q      <= bst_bl_d;
      bst_row_q     <= bst_row_d;
      bst_col_q     <= bst_col_d;
      bst_k_q       <= bst_k_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // One block RAM per byte lane so dqm maps directly onto lane write enables.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [2**STORE_AW];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (lane_we[gi] && !rst) mem[iss_idx] <= write_data[gi*8 +: 8];
      rd_q <= mem[iss_idx];
    end
    assign mem_rd[gi*8 +: 8] = rd_q;
  end

  sdram_rd_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .cl        (cl_q),
    .in_valid  (iss && !iss_wr),
    .in_mask   (dqm),
    .mem_q     (mem_rd),
    .out_data  (read_data),
    .out_valid (rd_valid),
    .busy      (pipe_busy)
  );

  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed bench for sdram_dev_model: mode/activate/write/read sequences with
// hand-computed data, burst wrap, byte masking, burst terminate, errors, reset.
module tb_sdram_dev_model;

  localparam logic [2:0] C_LMR = 3'b000, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_BT  = 3'b110;

  logic        clk = 1'b0, rst = 1'b1, cke = 1'b1, cs = 1'b1;
  logic        ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  dqm = 2'b00;
  logic [11:0] addr = '0;
  logic [1:0]  ba = '0;
  logic [15:0] write_data = '0;
  logic        wr_en = 1'b0;
  logic [15:0] read_data;
  logic        rd_valid, err;
  logic [3:0]  err_code;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] wd3  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] exp3 [4] = '{16'h1111, 16'h22AA, 16'h3333, 16'h4444};

  always #5 clk = ~clk;

  sdram_dev_model dut (
    .clk        (clk),
    .rst        (rst),
    .cke        (cke),
    .cs         (cs),
    .ras        (ras),
    .cas        (cas),
    .we         (we),
    .dqm        (dqm),
    .addr       (addr),
    .ba         (ba),
    .write_data (write_data),
    .wr_en      (wr_en),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
    cs = 1'b0;
    {ras, cas, we} = c;
    ba = b;
    addr = a;
  endtask

  task automatic nop();
    {ras, cas, we} = 3'b111;
  endtask

  task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
    set_cmd(c, b, a);
    tick();
    nop();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst read_data", 32'(read_data), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    cs = 1'b0;
    tick();

    // CL=2 BL=1 single write then read
    step(C_LMR, 2'd0, 12'h020);
    step(C_ACT, 2'd1, 12'h0A5);
    write_data = 16'hBEEF; wr_en = 1'b1;
    step(C_WR, 2'd1, 12'h010);
    wr_en = 1'b0;
    set_cmd(C_RD, 2'd1, 12'h010);
    tick(); nop();
    check("cl2 T+1 rd_valid", 32'(rd_valid), 32'd0);
    tick();
    check("cl2 T+2 rd_valid", 32'(rd_valid), 32'd1);
    check("cl2 T+2 data", 32'(read_data), 32'hBEEF);
    tick();
    check("cl2 T+3 rd_valid", 32'(rd_valid), 32'd0);
    check("cl2 T+3 data", 32'(read_data), 32'd0);
    check("cl2 err", 32'(err), 32'd0);

    // CL=3 BL=8 wrapped read starting at column 5
    step(C_PRE, 2'd0, 12'h400);
    step(C_LMR, 2'd0, 12'h033);
    step(C_ACT, 2'd1, 12'h0A5);
    wr_en = 1'b1;
    set_cmd(C_WR, 2'd1, 12'h000);
    for (int k = 0; k < 8; k++) begin
      write_data = 16'h1000 + 16'(k);
      tick(); nop();
    end
    wr_en = 1'b0;
    set_cmd(C_RD, 2'd1, 12'h005);
    tick(); nop();
    tick();
    check("bl8 T+2 rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("bl8 word%0d valid", i), 32'(rd_valid), 32'd1);
      check($sformatf("bl8 word%0d data", i), 32'(read_data), 32'h1000 + 32'((5 + i) % 8));
    end
    tick();
    check("bl8 after rd_valid", 32'(rd_valid), 32'd0);

    // CL=3 BL=4 byte-masked overwrite
    step(C_PRE, 2'd0, 12'h400);
    step(C_LMR, 2'd0, 12'h032);
    step(C_ACT, 2'd1, 12'h0A5);
    write_data = 16'hAAAA; wr_en = 1'b1;
    set_cmd(C_WR, 2'd1, 12'h020);
    for (int k = 0; k < 4; k++) begin
      tick(); nop();
    end
    set_cmd(C_WR, 2'd1, 12'h020);
    for (int k = 0; k < 4; k++) begin
      write_data = wd3[k];
      dqm = (k == 1) ? 2'b01 : 2'b00;
      tick(); nop();
    end
    dqm = 2'b00; wr_en = 1'b0;
    set_cmd(C_RD, 2'd1, 12'h020);
    tick(); nop();
    tick();
    check("mask T+2 rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mask word%0d valid", i), 32'(rd_valid), 32'd1);
      check($sformatf("mask word%0d data", i), 32'(read_data), 32'(exp3[i]));
    end
    tick();
    check("mask after rd_valid", 32'(rd_valid), 32'd0);

    // CL=2 BL=8 read cut by BURST_TERM two cycles later
    step(C_PRE, 2'd0, 12'h400);
    step(C_LMR, 2'd0, 12'h023);
    step(C_ACT, 2'd1, 12'h0A5);
    set_cmd(C_RD, 2'd1, 12'h000);
    tick(); nop();
    tick();
    check("bt T+2 valid", 32'(rd_valid), 32'd1);
    check("bt T+2 data", 32'(read_data), 32'h1000);
    set_cmd(C_BT, 2'd0, 12'h000);
    tick(); nop();
    check("bt T+3 valid", 32'(rd_valid), 32'd1);
    check("bt T+3 data", 32'(read_data), 32'h1001);
    tick();
    check("bt T+4 valid", 32'(rd_valid), 32'd1);
    check("bt T+4 data", 32'(read_data), 32'h1002);
    tick();
    check("bt T+5 valid", 32'(rd_valid), 32'd0);
    tick();
    check("bt T+6 valid", 32'(rd_valid), 32'd0);
    check("bt err", 32'(err), 32'd0);

    // READ to idle bank, then a second violation must not overwrite the code
    step(C_RD, 2'd2, 12'h000);
    check("idle err", 32'(err), 32'd1);
    check("idle err_code", 32'(err_code), 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle rd_valid %0d", i), 32'(rd_valid), 32'd0);
    end
    step(C_ACT, 2'd0, 12'h001);
    step(C_ACT, 2'd0, 12'h002);
    check("sticky err", 32'(err), 32'd1);
    check("sticky err_code", 32'(err_code), 32'd5);

    // Reset in the middle of a CL=3 BL=4 read
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst2 err", 32'(err), 32'd0);
    step(C_LMR, 2'd0, 12'h032);
    step(C_ACT, 2'd1, 12'h0A5);
    set_cmd(C_RD, 2'd1, 12'h020);
    tick(); nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst T+2 rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 3; i <= 6; i++) begin
      tick();
      check($sformatf("midrst T+%0d rd_valid", i), 32'(rd_valid), 32'd0);
    end
    check("midrst err", 32'(err), 32'd0);

    // READ before LOAD_MODE uses reset mode CL=3 BL=1
    step(C_ACT, 2'd1, 12'h0A5);
    set_cmd(C_RD, 2'd1, 12'h020);
    tick(); nop();
    check("nomode err", 32'(err), 32'd1);
    check("nomode err_code", 32'(err_code), 32'd6);
    tick();
    check("nomode T+2 valid", 32'(rd_valid), 32'd0);
    tick();
    check("nomode T+3 valid", 32'(rd_valid), 32'd1);
    check("nomode T+3 data", 32'(read_data), 32'h1111);
    tick();
    check("nomode T+4 valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
